// File: rtl/phase_pulse_seq_pkg.sv
// phase_pulse_pkg: shared FSM state encoding and default sizing constants
// for the phase_pulse_seq multi-phase pulse sequencer.
package phase_pulse_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam int NUM_PH_DEF = 5;
    localparam int CNT_W_DEF  = 8;
    localparam int RND_W_DEF  = 16;

endpackage

// File: rtl/phase_pulse_seq_timer.sv
// phase_timer: loadable down-counter used to time both the pulse and the gap
// intervals. Loading value N makes 'last' assert in the N-th cycle after the
// load edge, so the owner reloads on 'last' to chain intervals seamlessly.
module phase_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             last
);

    logic [CNT_W-1:0] cnt;

    // Count remaining cycles of the current interval, holding at zero.
    always_ff @(posedge clk) begin
        if (load) begin
            cnt <= load_val - CNT_W'(1);
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign last = (cnt == '0);

endmodule

// File: rtl/phase_pulse_seq.sv
// phase_pulse_seq: programmable multi-phase, non-overlapping pulse sequencer
// with round tick, start/busy/done handshake and a completed-round counter.
// Optional feature macro: PHASE_SEQ_MASK_EN adds a ph_mask input, latched at
// start, that silences selected phases while keeping their time slots.
module phase_pulse_seq
    import phase_pulse_pkg::*;
#(
    parameter int NUM_PH = NUM_PH_DEF,
    parameter int CNT_W  = CNT_W_DEF,
    parameter int RND_W  = RND_W_DEF
) (
    input  logic              main_clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    input  logic              stop,
    input  logic [CNT_W-1:0]  pulse_len,
    input  logic [CNT_W-1:0]  gap_len,
`ifdef PHASE_SEQ_MASK_EN
    input  logic [NUM_PH-1:0] ph_mask,
`endif
    output logic [NUM_PH-1:0] ph,
    output logic              ct,
    output logic              busy,
    output logic              done,
    output logic [RND_W-1:0]  round_cnt
);

    localparam int IDX_W = (NUM_PH > 1) ? $clog2(NUM_PH) : 1;
    localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(NUM_PH - 1);

    state_t            state;
    logic [IDX_W-1:0]  idx;
    logic [CNT_W-1:0]  len_q;
    logic [CNT_W-1:0]  gap_q;
    logic              mode_q;
    logic              stop_pend;
    logic [NUM_PH-1:0] mask_q;
    logic [NUM_PH-1:0] mask_in;

    logic              timer_load;
    logic [CNT_W-1:0]  timer_val;
    logic              timer_last;

    logic [CNT_W-1:0]  eff_len;
    logic              slot_end;
    logic              stop_now;

`ifdef PHASE_SEQ_MASK_EN
    assign mask_in = ph_mask;
`else
    assign mask_in = '1;
    assign mask_q  = '1;
`endif

    // A zero pulse length still gives a one-cycle pulse.
    assign eff_len = (pulse_len == '0) ? CNT_W'(1) : pulse_len;

    // A phase slot ends on the last pulse cycle when there is no gap,
    // otherwise on the last gap cycle.
    assign slot_end = timer_last &&
                      ((state == GAP) || ((state == PULSE) && (gap_q == '0)));

    // A stop arriving in the final cycle of a round still ends the run.
    assign stop_now = stop_pend || (stop && mode_q);

    function automatic logic [NUM_PH-1:0] strobe(input logic [IDX_W-1:0] i,
                                                 input logic [NUM_PH-1:0] m);
        strobe = (NUM_PH'(1) << i) & m;
    endfunction

    // Select what the interval timer is (re)loaded with at each interval end.
    always_comb begin
        timer_load = 1'b0;
        timer_val  = len_q;
        case (state)
            IDLE: begin
                timer_load = start;
                timer_val  = eff_len;
            end
            PULSE: begin
                timer_load = timer_last;
                timer_val  = (gap_q != '0) ? gap_q : len_q;
            end
            GAP: begin
                timer_load = timer_last;
                timer_val  = len_q;
            end
            default: begin
                timer_load = 1'b0;
            end
        endcase
    end

    phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (main_clk),
        .load     (timer_load),
        .load_val (timer_val),
        .last     (timer_last)
    );

    // Sequencer FSM with registered strobes, handshake and round counter.
    always_ff @(posedge main_clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            ph        <= '0;
            ct        <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            round_cnt <= '0;
            stop_pend <= 1'b0;
        end else begin
            ct   <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        len_q     <= eff_len;
                        gap_q     <= gap_len;
                        mode_q    <= mode;
`ifdef PHASE_SEQ_MASK_EN
                        mask_q    <= ph_mask;
`endif
                        idx       <= TOP_IDX;
                        ph        <= strobe(TOP_IDX, mask_in);
                        ct        <= 1'b1;
                        busy      <= 1'b1;
                        round_cnt <= '0;
                        state     <= PULSE;
                    end
                end
                PULSE: begin
                    if (stop && mode_q) stop_pend <= 1'b1;
                    if (timer_last && (gap_q != '0)) begin
                        ph    <= '0;
                        state <= GAP;
                    end
                end
                GAP: begin
                    if (stop && mode_q) stop_pend <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            if (slot_end) begin
                if (idx != '0) begin
                    idx   <= idx - IDX_W'(1);
                    ph    <= strobe(idx - IDX_W'(1), mask_q);
                    state <= PULSE;
                end else begin
                    round_cnt <= round_cnt + RND_W'(1);
                    if (mode_q && !stop_now) begin
                        idx   <= TOP_IDX;
                        ph    <= strobe(TOP_IDX, mask_q);
                        ct    <= 1'b1;
                        state <= PULSE;
                    end else begin
                        ph        <= '0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        stop_pend <= 1'b0;
                        state     <= IDLE;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_phase_pulse_seq.sv
// Testbench for phase_pulse_seq: directed scenarios plus randomized traffic,
// every cycle compared against a timeline model of the sequencer.
module tb_phase_pulse_seq;

    localparam int NUM_PH = 5;
    localparam int CNT_W  = 8;
    localparam int RND_W  = 16;

    logic              main_clk;
    logic              rst;
    logic              start;
    logic              mode;
    logic              stop;
    logic [CNT_W-1:0]  pulse_len;
    logic [CNT_W-1:0]  gap_len;
    logic [NUM_PH-1:0] ph_mask;
    logic [NUM_PH-1:0] ph;
    logic              ct;
    logic              busy;
    logic              done;
    logic [RND_W-1:0]  round_cnt;

    int checks = 0;
    int errors = 0;
    int ct_seen = 0;

    // Reference model state: a run is a position 't' within a round of
    // NUM_PH slots, each slot L pulse cycles followed by G gap cycles.
    int                m_run = 0;
    int                m_t = 0;
    int                m_rounds = 0;
    int                m_L = 1;
    int                m_G = 0;
    int                m_M = 0;
    int                m_stopp = 0;
    int                m_done = 0;
    logic [NUM_PH-1:0] m_mask = '1;

    phase_pulse_seq #(
        .NUM_PH (NUM_PH),
        .CNT_W  (CNT_W),
        .RND_W  (RND_W)
    ) dut (
        .main_clk  (main_clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .stop      (stop),
        .pulse_len (pulse_len),
        .gap_len   (gap_len),
`ifdef PHASE_SEQ_MASK_EN
        .ph_mask   (ph_mask),
`endif
        .ph        (ph),
        .ct        (ct),
        .busy      (busy),
        .done      (done),
        .round_cnt (round_cnt)
    );

    initial main_clk = 1'b0;
    always #5 main_clk = ~main_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance the model across one clock edge using the current inputs.
    task automatic model_edge();
        m_done = 0;
        if (rst) begin
            m_run = 0; m_t = 0; m_rounds = 0; m_stopp = 0;
        end else if (m_run == 0) begin
            if (start) begin
                m_run = 1; m_t = 0; m_rounds = 0; m_stopp = 0;
                m_L = (pulse_len == 0) ? 1 : int'(pulse_len);
                m_G = int'(gap_len);
                m_M = int'(mode);
`ifdef PHASE_SEQ_MASK_EN
                m_mask = ph_mask;
`else
                m_mask = '1;
`endif
            end
        end else begin
            if (stop && m_M == 1) m_stopp = 1;
            m_t++;
            if (m_t == NUM_PH * (m_L + m_G)) begin
                m_rounds++;
                if (m_M == 1 && m_stopp == 0) begin
                    m_t = 0;
                end else begin
                    m_run = 0; m_t = 0; m_stopp = 0; m_done = 1;
                end
            end
        end
    endtask

    task automatic compare_outputs();
        logic [NUM_PH-1:0] e_ph;
        int slot;
        e_ph = '0;
        if (m_run == 1) begin
            slot = m_L + m_G;
            if ((m_t % slot) < m_L)
                e_ph = (NUM_PH'(1) << (NUM_PH - 1 - m_t / slot)) & m_mask;
        end
        chk("ph", 32'(ph), 32'(e_ph));
        chk("ct", 32'(ct), 32'((m_run == 1) && (m_t == 0)));
        chk("busy", 32'(busy), 32'(m_run));
        chk("done", 32'(done), 32'(m_done));
        chk("round_cnt", 32'(round_cnt), 32'(m_rounds % (1 << RND_W)));
        chk("onehot", 32'($onehot0(ph)), 32'(1));
        if (ct === 1'b1) ct_seen++;
    endtask

    task automatic step();
        @(posedge main_clk);
        model_edge();
        #1;
        compare_outputs();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic idle_inputs();
        rst = 0; start = 0; stop = 0;
    endtask

    initial begin
        rst = 1; start = 0; mode = 0; stop = 0;
        pulse_len = 8'd2; gap_len = 8'd1; ph_mask = '1;
        run(2);

        // One-shot, L=2 G=1: 15-cycle round, done at cycle 16.
        idle_inputs();
        pulse_len = 2; gap_len = 1; mode = 0; start = 1;
        step();
        start = 0;
        run(18);
        chk("oneshot_rounds", 32'(round_cnt), 32'(1));

        // L=0, G=0: each phase one cycle, back-to-back.
        pulse_len = 0; gap_len = 0; start = 1;
        step();
        start = 0;
        run(8);

        // Continuous, stop pulsed in round 3.
        pulse_len = 1; gap_len = 1; mode = 1; start = 1;
        step();
        start = 0;
        ct_seen = 1;
        run(24);
        stop = 1;
        step();
        stop = 0;
        run(15);
        chk("ct_count", 32'(ct_seen), 32'(3));
        chk("stop_rounds", 32'(round_cnt), 32'(3));

        // Reset mid-round, then restart from the top phase.
        mode = 0; pulse_len = 2; gap_len = 1; start = 1;
        step();
        start = 0;
        run(5);
        rst = 1;
        step();
        rst = 0;
        chk("rst_busy", 32'(busy), 32'(0));
        start = 1;
        step();
        start = 0;
        chk("restart_ph", 32'(ph), 32'(1 << (NUM_PH - 1)));
        run(18);

        // start held high and inputs churned while busy: back-to-back runs.
        mode = 0; pulse_len = 1; gap_len = 0; start = 1;
        for (int i = 0; i < 20; i++) begin
            step();
            pulse_len = CNT_W'($urandom_range(0, 4));
            gap_len   = CNT_W'($urandom_range(0, 3));
        end
        start = 0;
        run(40);

        // Masked phases keep their slots.
        ph_mask = 5'b01010; mode = 0; pulse_len = 2; gap_len = 1; start = 1;
        step();
        start = 0;
        run(18);
        ph_mask = '1;

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            rst       = ($urandom_range(0, 199) == 0);
            start     = ($urandom_range(0, 3) == 0);
            stop      = ($urandom_range(0, 15) == 0);
            mode      = 1'($urandom_range(0, 1));
            pulse_len = CNT_W'($urandom_range(0, 3));
            gap_len   = CNT_W'($urandom_range(0, 2));
            ph_mask   = NUM_PH'($urandom);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
